uart_tx_framed: RTL and testbench

UART_TX_FRAMED -- requirements
Module: uart_tx_framed

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_fifo.sv | 74 +++++++
 rtl/uart_tx_framed.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_framed.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the framed UART transmitter.
// Holds the parity selector values, the FSM state encoding and the bit-period function.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Clocks per line bit; a zero baud rate yields 0 so the caller's range check rejects it.
  function automatic int unsigned bit_cycles(input int unsigned clock_freq,
                                             input int unsigned baud_rate);
    if (baud_rate == 0) begin
      return 0;
    end
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous write-data FIFO for the UART transmitter.
// Wrap-around pointers, occupancy counter and registered full/empty flags; read data falls through.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "uart_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             wr_ok;
  logic             rd_ok;

  // A full FIFO refuses the write even if a pop frees a slot in the same cycle.
  assign wr_ok = wr_en_i && !full_o;
  assign rd_ok = rd_en_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CW'(1);
    end else if (!wr_ok && rd_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_o   <= 1'b0;
      empty_o  <= 1'b1;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      full_o  <= (count_d == CW'(DEPTH));
      empty_o <= (count_d == '0);
    end
  end

  // Storage needs no reset: the flags guarantee stale entries are never read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o = mem[rd_ptr_q];

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: write FIFO feeding a start/data/parity/stop serialiser.
// Line outputs are registered from the current state, so the line trails the FSM by one clock.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_ni,
  input  logic [DATA_BITS-1:0] din_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 tx_done_tick_o,
  output logic                 busy_o,
  output logic                 fifo_full_o,
  output logic                 fifo_empty_o
);

  localparam int unsigned BIT_CYCLES = bit_cycles(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned TIMER_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned CNT_W      = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 2;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DATA_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]   STOP_LAST  = CNT_W'(STOP_BITS - 1);
  localparam logic               HAS_PARITY = (PARITY != PARITY_NONE);
  localparam logic               ODD_PARITY = (PARITY == PARITY_ODD);

  if (BIT_CYCLES < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > PARITY_EVEN
      || (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2
      || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $fatal(1, "uart_tx_framed: illegal parameter value");
  end

  tx_state_e            state_q;
  tx_state_e            state_d;
  logic [TIMER_W-1:0]   timer_q;
  logic [TIMER_W-1:0]   timer_d;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [CNT_W-1:0]     bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 par_q;
  logic                 par_d;
  logic                 tx_d;
  logic                 done_d;
  logic                 busy_d;
  logic                 pop_c;
  logic                 bit_end_c;
  logic [DATA_BITS-1:0] fifo_dout;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .wr_en_i (valid_i),
    .din_i   (din_i),
    .rd_en_i (pop_c),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full_o),
    .empty_o (fifo_empty_o)
  );

  assign ready_o   = !fifo_full_o;
  assign bit_end_c = (timer_q == TIMER_LAST);

  // Next-state, datapath and line-level decode.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tx_d      = 1'b1;
    done_d    = 1'b0;
    pop_c     = 1'b0;

    if (state_q != ST_IDLE) begin
      timer_d = bit_end_c ? '0 : timer_q + TIMER_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        pop_c = !fifo_empty_o;
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_end_c) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (bit_end_c) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = HAS_PARITY ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        tx_d = par_q;
        if (bit_end_c) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          if (bit_cnt_q == STOP_LAST) begin
            done_d    = 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
            pop_c     = !fifo_empty_o;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // One load path serves both a start from IDLE and a gap-free follow-on frame.
    if (pop_c) begin
      shift_d   = fifo_dout;
      par_d     = (^fifo_dout) ^ ODD_PARITY;
      state_d   = ST_START;
      timer_d   = '0;
      bit_cnt_d = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      par_q          <= 1'b0;
      tx_o           <= 1'b1;
      tx_done_tick_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      par_q          <= par_d;
      tx_o           <= tx_d;
      tx_done_tick_o <= done_d;
      busy_o         <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: five parameterisations (8N1/depth 4, 8E1, 8O1, 8N2, 5E1) at 10 clocks per bit,
// each checked clock by clock against an expected line/done-tick queue filled when words are written.
module tb_uart_tx_framed;

  localparam int unsigned CF   = 100_000_000;
  localparam int unsigned BR   = 10_000_000;
  localparam int unsigned BC   = 10;
  localparam int unsigned NDUT = 5;

  typedef struct packed {
    logic tx;
    logic done;
  } exp_t;

  logic            clk = 1'b0;
  logic [NDUT-1:0] rst_n;
  logic [NDUT-1:0] vld;
  logic [7:0]      din [NDUT];
  wire  [NDUT-1:0] rdy;
  wire  [NDUT-1:0] txl;
  wire  [NDUT-1:0] done;
  wire  [NDUT-1:0] busy;
  wire  [NDUT-1:0] full;
  wire  [NDUT-1:0] empty;

  exp_t        exp_q [$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  uart_tx_framed #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                   .FIFO_DEPTH(4)) u_dut_8n1 (
    .clk(clk), .rst_ni(rst_n[0]), .din_i(din[0]), .valid_i(vld[0]), .ready_o(rdy[0]),
    .tx_o(txl[0]), .tx_done_tick_o(done[0]), .busy_o(busy[0]), .fifo_full_o(full[0]),
    .fifo_empty_o(empty[0]));

  uart_tx_framed #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                   .FIFO_DEPTH(16)) u_dut_8e1 (
    .clk(clk), .rst_ni(rst_n[1]), .din_i(din[1]), .valid_i(vld[1]), .ready_o(rdy[1]),
    .tx_o(txl[1]), .tx_done_tick_o(done[1]), .busy_o(busy[1]), .fifo_full_o(full[1]),
    .fifo_empty_o(empty[1]));

  uart_tx_framed #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                   .FIFO_DEPTH(16)) u_dut_8o1 (
    .clk(clk), .rst_ni(rst_n[2]), .din_i(din[2]), .valid_i(vld[2]), .ready_o(rdy[2]),
    .tx_o(txl[2]), .tx_done_tick_o(done[2]), .busy_o(busy[2]), .fifo_full_o(full[2]),
    .fifo_empty_o(empty[2]));

  uart_tx_framed #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2),
                   .FIFO_DEPTH(16)) u_dut_8n2 (
    .clk(clk), .rst_ni(rst_n[3]), .din_i(din[3]), .valid_i(vld[3]), .ready_o(rdy[3]),
    .tx_o(txl[3]), .tx_done_tick_o(done[3]), .busy_o(busy[3]), .fifo_full_o(full[3]),
    .fifo_empty_o(empty[3]));

  uart_tx_framed #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(5), .PARITY(2), .STOP_BITS(1),
                   .FIFO_DEPTH(16)) u_dut_5e1 (
    .clk(clk), .rst_ni(rst_n[4]), .din_i(din[4][4:0]), .valid_i(vld[4]), .ready_o(rdy[4]),
    .tx_o(txl[4]), .tx_done_tick_o(done[4]), .busy_o(busy[4]), .fifo_full_o(full[4]),
    .fifo_empty_o(empty[4]));

  // Expected line model: n clocks at one level, done tick flagged on the final clock if asked.
  task automatic push_bit(input logic level, input int unsigned n, input logic done_last);
    for (int unsigned c = 0; c < n; c++) begin
      exp_q.push_back({level, done_last && (c == n - 1)});
    end
  endtask

  task automatic push_frame(input logic [8:0] data, input int unsigned dbits,
                            input int unsigned par, input int unsigned stops);
    logic p;
    p = 1'b0;
    for (int i = 0; i < int'(dbits); i++) p = p ^ data[i];
    if (par == 1) p = ~p;
    push_bit(1'b0, BC, 1'b0);
    for (int i = 0; i < int'(dbits); i++) push_bit(data[i], BC, 1'b0);
    if (par != 0) push_bit(p, BC, 1'b0);
    push_bit(1'b1, BC * stops, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = '0;
    vld   = '0;
    for (int k = 0; k < int'(NDUT); k++) din[k] = 8'h00;
    #12;
    for (int k = 0; k < int'(NDUT); k++) begin
      checks++; if (txl[k] !== 1'b1)   begin errors++; $display("FAIL reset tx dut%0d got=%b exp=1", k, txl[k]); end
      checks++; if (done[k] !== 1'b0)  begin errors++; $display("FAIL reset done dut%0d got=%b exp=0", k, done[k]); end
      checks++; if (busy[k] !== 1'b0)  begin errors++; $display("FAIL reset busy dut%0d got=%b exp=0", k, busy[k]); end
      checks++; if (empty[k] !== 1'b1) begin errors++; $display("FAIL reset empty dut%0d got=%b exp=1", k, empty[k]); end
      checks++; if (full[k] !== 1'b0)  begin errors++; $display("FAIL reset full dut%0d got=%b exp=0", k, full[k]); end
      checks++; if (rdy[k] !== 1'b1)   begin errors++; $display("FAIL reset ready dut%0d got=%b exp=1", k, rdy[k]); end
    end
    @(posedge clk); #1;
    rst_n = '1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_8n1_a5();
    logic [9:0] a5_line;
    a5_line = 10'b1101001010;
    exp_q.delete();
    push_bit(1'b1, 2, 1'b0);
    for (int i = 0; i < 10; i++) push_bit(a5_line[i], BC, i == 9);
    push_bit(1'b1, 4, 1'b0);
    @(posedge clk); #1;
    vld[0] = 1'b1; din[0] = 8'hA5;
    for (int t = 0; exp_q.size() > 0; t++) begin
      exp_t e;
      @(posedge clk); #1;
      vld[0] = 1'b0; din[0] = 8'hFF;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (txl[0] !== e.tx)   begin errors++; $display("FAIL 8n1_a5 tx t=%0d got=%b exp=%b", t, txl[0], e.tx); end
      checks++; if (done[0] !== e.done) begin errors++; $display("FAIL 8n1_a5 done t=%0d got=%b exp=%b", t, done[0], e.done); end
      if (t == 0) begin
        checks++; if (empty[0] !== 1'b0) begin errors++; $display("FAIL 8n1_a5 empty_after_write got=%b exp=0", empty[0]); end
        checks++; if (busy[0] !== 1'b0)  begin errors++; $display("FAIL 8n1_a5 busy_before_pop got=%b exp=0", busy[0]); end
      end
      if (t == 1 || t == 50) begin
        checks++; if (busy[0] !== 1'b1)  begin errors++; $display("FAIL 8n1_a5 busy t=%0d got=%b exp=1", t, busy[0]); end
        checks++; if (empty[0] !== 1'b1) begin errors++; $display("FAIL 8n1_a5 empty_after_pop t=%0d got=%b exp=1", t, empty[0]); end
      end
    end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL 8n1_a5 busy_end got=%b exp=0", busy[0]); end
  endtask

  task automatic test_parity_even();
    exp_q.delete();
    push_bit(1'b1, 2, 1'b0);
    push_frame(9'h007, 8, 2, 1);
    push_frame(9'h096, 8, 2, 1);
    push_bit(1'b1, 3, 1'b0);
    @(posedge clk); #1;
    vld[1] = 1'b1; din[1] = 8'h07;
    for (int t = 0; exp_q.size() > 0; t++) begin
      exp_t e;
      @(posedge clk); #1;
      if (t == 0) din[1] = 8'h96;
      else begin vld[1] = 1'b0; din[1] = 8'h3C; end
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (txl[1] !== e.tx)   begin errors++; $display("FAIL 8e1 tx t=%0d got=%b exp=%b", t, txl[1], e.tx); end
      checks++; if (done[1] !== e.done) begin errors++; $display("FAIL 8e1 done t=%0d got=%b exp=%b", t, done[1], e.done); end
    end
  endtask

  task automatic test_parity_odd();
    exp_q.delete();
    push_bit(1'b1, 2, 1'b0);
    push_frame(9'h007, 8, 1, 1);
    push_bit(1'b1, 3, 1'b0);
    @(posedge clk); #1;
    vld[2] = 1'b1; din[2] = 8'h07;
    for (int t = 0; exp_q.size() > 0; t++) begin
      exp_t e;
      @(posedge clk); #1;
      vld[2] = 1'b0; din[2] = 8'hF8;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (txl[2] !== e.tx)   begin errors++; $display("FAIL 8o1 tx t=%0d got=%b exp=%b", t, txl[2], e.tx); end
      checks++; if (done[2] !== e.done) begin errors++; $display("FAIL 8o1 done t=%0d got=%b exp=%b", t, done[2], e.done); end
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] w [6];
    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_q.delete();
    push_bit(1'b1, 2, 1'b0);
    for (int i = 0; i < 5; i++) push_frame({1'b0, w[i]}, 8, 0, 1);
    push_bit(1'b1, 4, 1'b0);
    @(posedge clk); #1;
    vld[0] = 1'b1; din[0] = w[0];
    for (int t = 0; exp_q.size() > 0; t++) begin
      exp_t e;
      @(posedge clk); #1;
      if (t + 1 < 6) din[0] = w[t + 1];
      else begin vld[0] = 1'b0; din[0] = 8'h00; end
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (txl[0] !== e.tx)   begin errors++; $display("FAIL fifo_full tx t=%0d got=%b exp=%b", t, txl[0], e.tx); end
      checks++; if (done[0] !== e.done) begin errors++; $display("FAIL fifo_full done t=%0d got=%b exp=%b", t, done[0], e.done); end
      if (t < 5) begin
        checks++; if (rdy[0] !== (t < 4)) begin errors++; $display("FAIL fifo_full ready t=%0d got=%b exp=%b", t, rdy[0], t < 4); end
        checks++; if (full[0] !== (t == 4)) begin errors++; $display("FAIL fifo_full full t=%0d got=%b exp=%b", t, full[0], t == 4); end
      end
    end
    checks++; if (empty[0] !== 1'b1) begin errors++; $display("FAIL fifo_full empty_end got=%b exp=1", empty[0]); end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    push_bit(1'b1, 2, 1'b0);
    push_frame(9'h03C, 8, 0, 2);
    push_frame(9'h0C3, 8, 0, 2);
    push_bit(1'b1, 3, 1'b0);
    @(posedge clk); #1;
    vld[3] = 1'b1; din[3] = 8'h3C;
    for (int t = 0; exp_q.size() > 0; t++) begin
      exp_t e;
      @(posedge clk); #1;
      if (t == 0) din[3] = 8'hC3;
      else begin vld[3] = 1'b0; din[3] = 8'h00; end
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (txl[3] !== e.tx)   begin errors++; $display("FAIL 8n2_b2b tx t=%0d got=%b exp=%b", t, txl[3], e.tx); end
      checks++; if (done[3] !== e.done) begin errors++; $display("FAIL 8n2_b2b done t=%0d got=%b exp=%b", t, done[3], e.done); end
      if (t == 111) begin
        checks++; if (busy[3] !== 1'b1) begin errors++; $display("FAIL 8n2_b2b busy_between got=%b exp=1", busy[3]); end
      end
    end
  endtask

  task automatic test_5bit();
    exp_q.delete();
    push_bit(1'b1, 2, 1'b0);
    push_frame(9'h01F, 5, 2, 1);
    push_bit(1'b1, 3, 1'b0);
    @(posedge clk); #1;
    vld[4] = 1'b1; din[4] = 8'h1F;
    for (int t = 0; exp_q.size() > 0; t++) begin
      exp_t e;
      @(posedge clk); #1;
      vld[4] = 1'b0; din[4] = 8'h00;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (txl[4] !== e.tx)   begin errors++; $display("FAIL 5e1 tx t=%0d got=%b exp=%b", t, txl[4], e.tx); end
      checks++; if (done[4] !== e.done) begin errors++; $display("FAIL 5e1 done t=%0d got=%b exp=%b", t, done[4], e.done); end
    end
  endtask

  task automatic test_reset_midframe();
    @(posedge clk); #1;
    vld[0] = 1'b1; din[0] = 8'h52;
    @(posedge clk); #1;
    din[0] = 8'h33;
    @(posedge clk); #1;
    vld[0] = 1'b0; din[0] = 8'hFF;
    repeat (44) @(posedge clk);
    #3;
    checks++; if (txl[0] !== 1'b0)   begin errors++; $display("FAIL midreset pre_tx_bit3 got=%b exp=0", txl[0]); end
    checks++; if (busy[0] !== 1'b1)  begin errors++; $display("FAIL midreset pre_busy got=%b exp=1", busy[0]); end
    checks++; if (empty[0] !== 1'b0) begin errors++; $display("FAIL midreset pre_empty got=%b exp=0", empty[0]); end
    rst_n[0] = 1'b0;
    #1;
    checks++; if (txl[0] !== 1'b1)   begin errors++; $display("FAIL midreset tx got=%b exp=1", txl[0]); end
    checks++; if (busy[0] !== 1'b0)  begin errors++; $display("FAIL midreset busy got=%b exp=0", busy[0]); end
    checks++; if (empty[0] !== 1'b1) begin errors++; $display("FAIL midreset empty got=%b exp=1", empty[0]); end
    checks++; if (full[0] !== 1'b0)  begin errors++; $display("FAIL midreset full got=%b exp=0", full[0]); end
    checks++; if (rdy[0] !== 1'b1)   begin errors++; $display("FAIL midreset ready got=%b exp=1", rdy[0]); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL midreset done c=%0d got=%b exp=0", c, done[0]); end
    end
    exp_q.delete();
    push_bit(1'b1, 2, 1'b0);
    push_frame(9'h096, 8, 0, 1);
    push_bit(1'b1, 5, 1'b0);
    @(posedge clk); #1;
    rst_n[0] = 1'b1; vld[0] = 1'b1; din[0] = 8'h96;
    for (int t = 0; exp_q.size() > 0; t++) begin
      exp_t e;
      @(posedge clk); #1;
      vld[0] = 1'b0; din[0] = 8'h00;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (txl[0] !== e.tx)   begin errors++; $display("FAIL midreset_after tx t=%0d got=%b exp=%b", t, txl[0], e.tx); end
      checks++; if (done[0] !== e.done) begin errors++; $display("FAIL midreset_after done t=%0d got=%b exp=%b", t, done[0], e.done); end
    end
  endtask

  initial begin
    test_reset();
    test_8n1_a5();
    test_parity_even();
    test_parity_odd();
    test_fifo_full();
    test_back_to_back();
    test_5bit();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
